ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the post-forwarding operands, i.e. the outputs of the EX operand muxes steered by ForwardA/ForwardB.
- Raises a stall request so the IF/ID/EX pipeline registers freeze while it iterates.
- Delivers the result to the EX/MEM register with a done pulse.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
CNT_W, 5, iteration counter width ($clog2(XLEN))

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  ID/EX holds a valid M-extension op (opcode 0110011, funct7 0000001)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  forwarded rs1 value
op_b  input  XLEN  forwarded rs2 value
flush  input  1  EX flush (branch/jump redirect), synchronous
stall_in  input  1  external pipeline freeze (e.g. memory stall)
stall_req  output  1  to hazard logic: freeze PC, IF/ID, ID/EX; bubble EX/MEM
done  output  1  result valid for this EX instruction
result  output  XLEN  result to EX/MEM ALU-result path

Behaviour:
- Reset (rstn low, async): state IDLE, counter 0, result 0, done 0; stall_req is 0 while in reset.
- States: IDLE, RUN, DONE.
- stall_req = (IDLE && start && !flush) || RUN. This is the only combinational path from inputs; done is registered.
- IDLE, start=1, normal case:
  - Latch |op_a|, |op_b| and the result sign.
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU/DIVU/REMU: both unsigned.
  - Latch funct3; counter = 0; go to RUN.
- IDLE, start=1, special case (fast path, no RUN):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow, DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
  - Write result at the edge; go straight to DONE (done at cycle 1).
- RUN, multiply: one shift-add step per cycle into a 2*XLEN accumulator.
- RUN, divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- RUN exit: after XLEN steps (counter==XLEN-1 at the edge):
  - Apply sign fix (two's-complement negate if sign set).
  - Select the low/high product word, or quotient/remainder.
  - Write result; go to DONE.
- Remainder sign follows the dividend. Quotient sign is the XOR of the operand signs.
- Normal latency: start seen in cycle 0; stall_req high cycles 0..XLEN (33 cycles); done=1 in cycle XLEN+1.
- DONE:
  - done=1, stall_req=0.
  - start is ignored (same instruction still present).
  - stall_in=1 -> stay in DONE, done held high, result stable.
  - stall_in=0 -> IDLE next edge.
- result holds its last value until the next completed operation; it is never cleared except by reset.
- flush=1 in any state: go to IDLE next edge, done=0, result unchanged, operation discarded. flush together with start in IDLE does not start an operation.
- stall_in during RUN has no effect; iteration continues.
- start=0 in IDLE: stay IDLE, outputs quiet.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> stall_req high 33 cycles, done in cycle 33, result=0xFFFFFFEB; done drops the next cycle.
- Upper-word products, op_a=op_b=0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE.
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Fast-path specials, each with done in cycle 1, stall_req high only in cycle 0:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- flush asserted at RUN cycle 10 -> IDLE next cycle, stall_req=0, no done, result keeps the prior value; a following MULHU 3*5 -> 0 with correct latency.
- stall_in high 3 cycles on entering DONE -> done high 3+1 cycles, no restart despite start=1.
- rstn pulsed low mid-RUN -> stall_req, done and result go to 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Uses one shift-add or restoring-divide step per cycle and holds the pipeline with stall_req while it runs.
//
// state | meaning
// IDLE  | waiting for an M-extension op; fast-path specials complete from here
// RUN   | iterating, one step per cycle, XLEN steps total
// DONE  | result valid, done high until the pipeline moves (stall_in low)
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    input  logic            stall_in,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mag_b;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;

    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes are unsigned; abs(MIN_INT) stays MIN_INT, which is the correct magnitude.
    assign neg_a = a_signed & op_a[XLEN-1];
    assign neg_b = b_signed & op_b[XLEN-1];
    assign abs_a = neg_a ? (~op_a + 1'b1) : op_a;
    assign abs_b = neg_b ? (~op_b + 1'b1) : op_b;

    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                      (op_a == MIN_INT) && (op_b == '1);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            fast_res = funct3[1] ? '0 : MIN_INT;
    end

    // acc holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_b};
        mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
        div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_next  = op_q[2] ? div_next : mul_next;
    end

    always_comb begin
        prod_fix = neg_q ? (~acc_next + 1'b1) : acc_next;
        quo_fix  = neg_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
        rem_fix  = neg_r ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag_b  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (fast) begin
                            result <= fast_res;
                            state  <= ST_DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            mag_b <= abs_b;
                            op_q  <= funct3;
                            neg_q <= neg_a ^ neg_b;
                            neg_r <= neg_a;
                            cnt   <= '0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            result <= final_res;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush || !stall_in)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rstn so the hazard unit never sees a freeze while the unit is held in reset.
    assign stall_req = rstn && (((state == ST_IDLE) && start && !flush) || (state == ST_RUN));
    assign done      = (state == ST_DONE);

endmodule
